mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Moore FSM that generates every mux select and write strobe for the multicycle MIPS datapath (IorD, ALUSrcA/B, MemtoReg, RegDst, PCSource selects plus enables).
It sits between the instruction register opcode field and the datapath muxes.
It sequences fetch/decode/execute/memory/writeback and stalls on a memory-ready handshake.

Parameters:
OPC_W, 6, opcode field width (fixed by ISA; no other value legal)
STATE_W, 4, state register width

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; one clock; asynchronous, active-high
opcode  in  6  instr[31:26] from IR, sampled in DECODE
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (branch)
i_or_d  out  1  mem addr mux: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  write-data mux: 0=ALUOut, 1=MDR
reg_dst  out  1  dest mux: 0=rt, 1=rd
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=signext, 11=signext<<2
alu_op  out  2  00=add, 01=sub, 10=funct, 11=add (ADDI)
pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
state  out  4  current state (debug)

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=12
  - Unused encodings go to FETCH.
- Async reset: state=FETCH. While rst=1, all outputs are forced to 0 and state reads 0.
- Outputs are decoded from the registered state, with no combinational path from opcode. Strobes not listed for a state are 0; selects not listed are 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR
  - 000000 (R-type) -> EXEC
  - 000100 (BEQ) -> BRANCH
  - 000010 (J) -> JUMP
  - 001000 (ADDI) -> ADDI_EX
  - anything else -> illegal handling (see Optional Feature)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for LW, MEM_WR for SW. Opcode is held stable by the IR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=11 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- Latency with mem_ready held at 1 (cycles from entering FETCH to re-entering FETCH): R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- mem_read and mem_write are never both 1.
- Reset mid-instruction: abandons the instruction immediately; no strobe is asserted after rst rises.

Optional Feature:
MIPS_CTRL_ILLEGAL_TRAP_EN
- Defined: illegal opcode in DECODE -> TRAP. TRAP drives all strobes 0 and holds until reset. The extra output port illegal_op (out, 1) is 1 only in TRAP.
- Undefined: an illegal opcode is a NOP (DECODE -> FETCH). The TRAP encoding is unused and the illegal_op port is absent.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - state enum/localparams
  - ALUOp codes
  - ALUSrcB and PCSource select codes
- One sub-module, mips_ctrl_outdec: purely combinational state-to-control-word decoder. The parent holds the state register and next-state logic.

Test Plan:
- rst=1 mid-MEM_RD with mem_ready=0 -> all outputs 0 immediately; after release, state=0, mem_read=1 next cycle.
- LW (100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; 5 cycles total.
- SW (101011), mem_ready low 3 cycles in MEM_WR -> mem_write=1, i_or_d=1 held 4 cycles; exactly one cycle with mem_ready=1 before FETCH.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_write=0 while stalled, 1 in the ready cycle, then DECODE.
- R-type, BEQ, J, ADDI back-to-back -> visit counts 4/3/3/4; BEQ shows alu_op=01, pc_write_cond=1, pc_source=01; J shows pc_source=10, pc_write=1.
- Opcode 111111 -> with macro defined: state=12, illegal_op=1 held until reset. Without macro: returns to FETCH after DECODE and no write strobe is asserted.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS controller:
//   - opcode constants for the supported instruction classes
//   - FSM state encoding
//   - ALUOp, ALUSrcB and PCSource select codes
//   - ctrl_t: the full control word driven onto the datapath
// Optional feature macro: MIPS_CTRL_ILLEGAL_TRAP_EN (TRAP state in use).
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int OPC_W   = 6;
   localparam int STATE_W = 4;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11,
      S_TRAP     = 4'd12
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_ADDI  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCB_B        = 2'b00,
      SRCB_FOUR     = 2'b01,
      SRCB_SEXT     = 2'b10,
      SRCB_SEXT_SH2 = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_src_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      alu_src_b_e alu_src_b;
      alu_op_e    alu_op;
      pc_src_e    pc_source;
   } ctrl_t;

   // All strobes off, all selects at their zero encoding.
   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// -----------------------------------------------------------------------------
// mips_ctrl_outdec
// Purely combinational Moore decoder: registered FSM state -> control word.
// The only input besides the state is mem_ready, which gates the FETCH-cycle
// IR/PC loads so they fire on the cycle the instruction word arrives.
// Optional feature macro: MIPS_CTRL_ILLEGAL_TRAP_EN (TRAP decodes to idle
// either way; the state simply never occurs when the macro is undefined).
// Ports:
//   state     in   current FSM state
//   mem_ready in   memory completes its access this cycle
//   ctrl      out  control word for the datapath
// -----------------------------------------------------------------------------
module mips_ctrl_outdec
   import mips_pkg::*;
(
   input  state_e state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: the default assignment first means every path writes every
      // field, so no latch can be inferred for fields a state leaves alone.
      ctrl = CTRL_IDLE;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            // Precompute branch target in ALUOut while registers are read.
            ctrl.alu_src_b = SRCB_SEXT_SH2;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALU_ADDI;
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         default: begin
            // TRAP and unused encodings: everything off.
            ctrl = CTRL_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore FSM sequencing fetch/decode/execute/memory/writeback for the multicycle
// MIPS datapath. Holds the state register and next-state logic; the control
// word is produced by mips_ctrl_outdec from the registered state only, so no
// combinational path exists from opcode to any output.
// Optional feature macro: MIPS_CTRL_ILLEGAL_TRAP_EN
//   defined   : illegal opcode -> TRAP (held until reset), illegal_op port
//   undefined : illegal opcode behaves as a NOP (DECODE -> FETCH)
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   opcode          instr[31:26] from the IR
//   mem_ready       memory completes the current access this cycle
//   pc_write .. pc_source  datapath strobes and mux selects
//   state           current FSM state (debug)
//   illegal_op      (macro only) high while in TRAP
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int OPC_W   = 6,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   output logic               illegal_op,
`endif
   output logic [STATE_W-1:0] state
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl_raw;
   ctrl_t  ctrl;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values,
      // independent of the order the simulator evaluates processes.
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               default:      state_d = S_TRAP;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         // Only LW and SW reach MEM_ADDR, and the IR holds opcode stable.
         S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:   state_d = S_FETCH;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_EXEC:     state_d = S_R_WB;
         S_R_WB:     state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_ADDI_EX:  state_d = S_ADDI_WB;
         S_ADDI_WB:  state_d = S_FETCH;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         S_TRAP:     state_d = S_TRAP;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------------------
   mips_ctrl_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl_raw)
   );

   // NOTE: outputs are masked by rst combinationally so that no strobe
   // survives even the partial cycle between rst rising and the next edge.
   always_comb begin
      ctrl = rst ? CTRL_IDLE : ctrl_raw;
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign state         = state_q;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   assign illegal_op    = (state_q == S_TRAP) && !rst;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Scoreboard bench. The stimulus process walks each instruction through the
// list of states the instruction class visits, drives mem_ready/opcode, and
// pushes the expected state + control word for that cycle into a queue. A
// monitor process pops and compares on every falling edge.
// Honors MIPS_CTRL_ILLEGAL_TRAP_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       pcwc;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic       m2r;
      logic       rdst;
      logic       rw;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       ill;
   } exp_t;

   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_ADDI = 6'b001000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;
   logic       illegal_op;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   mips_multicycle_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      .illegal_op    (illegal_op),
`endif
      .state         (state)
   );

`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
   assign illegal_op = 1'b0;
`endif

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   // Reference: what each named step of an instruction must drive.
   function automatic exp_t model_word(int st, bit mr, bit in_rst);
      exp_t e;
      e = '0;
      if (in_rst) return e;
      e.st = st[3:0];
      case (st)
         0:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
         1:  e.srcb = 2'b11;
         2:  begin e.srca = 1; e.srcb = 2'b10; end
         3:  begin e.mrd = 1; e.iord = 1; end
         4:  begin e.rw = 1; e.m2r = 1; end
         5:  begin e.mwr = 1; e.iord = 1; end
         6:  begin e.srca = 1; e.aluop = 2'b10; end
         7:  begin e.rw = 1; e.rdst = 1; end
         8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; end
         9:  begin e.pcw = 1; e.pcsrc = 2'b10; end
         10: begin e.srca = 1; e.srcb = 2'b10; e.aluop = 2'b11; end
         11: e.rw = 1;
         12: e.ill = 1;
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.st    = state;
      a.pcw   = pc_write;
      a.pcwc  = pc_write_cond;
      a.iord  = i_or_d;
      a.mrd   = mem_read;
      a.mwr   = mem_write;
      a.irw   = ir_write;
      a.m2r   = mem_to_reg;
      a.rdst  = reg_dst;
      a.rw    = reg_write;
      a.srca  = alu_src_a;
      a.srcb  = alu_src_b;
      a.aluop = alu_op;
      a.pcsrc = pc_source;
      a.ill   = illegal_op;
      return a;
   endfunction

   // Monitor: compare every cycle the stimulus has posted an expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("cycle st=%0d", e.st), 32'(actual()), 32'(e));
         if (mem_read && mem_write) check("rd_wr_exclusive", 32'd1, 32'd0);
      end
   end

   task automatic push(int st, bit mr);
      exp_q.push_back(model_word(st, mr, rst));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1 of a cycle. Stall counts < 0 mean random.
   task automatic run_instr(logic [5:0] op, int fetch_stall, int mem_stall);
      int seq[$];
      seq.push_back(0);
      seq.push_back(1);
      case (op)
         T_R:     begin seq.push_back(6);  seq.push_back(7);  end
         T_LW:    begin seq.push_back(2);  seq.push_back(3);  seq.push_back(4); end
         T_SW:    begin seq.push_back(2);  seq.push_back(5);  end
         T_BEQ:   seq.push_back(8);
         T_J:     seq.push_back(9);
         T_ADDI:  begin seq.push_back(10); seq.push_back(11); end
         default: ;
      endcase
      foreach (seq[k]) begin
         int  waited;
         int  stall;
         bit  waits;
         bit  mr;
         waited = 0;
         waits  = (seq[k] == 0) || (seq[k] == 3) || (seq[k] == 5);
         stall  = (seq[k] == 0) ? fetch_stall : mem_stall;
         forever begin
            if (!waits)          mr = 1'($urandom_range(0, 1));
            else if (stall >= 0) mr = (waited >= stall);
            else                 mr = (waited >= 5) || ($urandom_range(0, 2) != 0);
            mem_ready = mr;
            // IR contents are irrelevant while fetching; scramble them.
            opcode = (seq[k] == 0) ? 6'($urandom) : op;
            push(seq[k], mr);
            step();
            if (!waits || mr) break;
            waited++;
         end
      end
   endtask

   task automatic do_reset(int cycles);
      rst = 1'b1;
      #1;
      check("rst_immediate", 32'(actual()), 32'd0);
      for (int i = 0; i < cycles; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         push(0, mem_ready);
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [5:0] ops[6];
      ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'(actual()), 32'd0);
      rst = 1'b0;

      run_instr(T_R, 2, 0);      // fetch stall, ir/pc_write only on ready cycle
      run_instr(T_LW, 0, 0);     // states 0,1,2,3,4
      run_instr(T_SW, 0, 3);     // MEM_WR held 4 cycles
      run_instr(T_R, 0, 0);      // back-to-back R, BEQ, J, ADDI
      run_instr(T_BEQ, 0, 0);
      run_instr(T_J, 0, 0);
      run_instr(T_ADDI, 0, 0);

      // Illegal opcode
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      run_instr(6'b111111, 0, 0);
      for (int i = 0; i < 5; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         opcode    = 6'($urandom);
         push(12, mem_ready);
         step();
      end
      do_reset(2);
`else
      run_instr(6'b111111, 0, 0);
`endif

      // Reset while stalled in MEM_RD
      mem_ready = 1'b1; opcode = 6'($urandom); push(0, 1); step();
      opcode = T_LW; push(1, 1); step();
      push(2, 1); step();
      mem_ready = 1'b0; push(3, 0); step();
      do_reset(2);
      run_instr(T_ADDI, 0, 0);   // FETCH with mem_read=1 right after release

      // Randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         logic [5:0] op;
         op = ops[$urandom_range(0, 5)];
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
         if ($urandom_range(0, 9) == 0) begin
            op = 6'($urandom);
            while (op inside {T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI}) op = 6'($urandom);
         end
`endif
         run_instr(op, -1, -1);
      end

      step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
